ram_single_port_arbiter: RTL and testbench

- Shares one single-port block RAM (ram_single_18k instance, DO_REG=0, one-cycle read latency) between two requesters, port 0 and port 1.
- Each requester issues read or write commands over a valid/ready handshake.
- Reads return data on a per-port rd_valid/rd_data strobe.
- Sits between datapath stages (e.g. FFT twiddle/buffer logic) and the RAM wrapper; the RAM pins are driven only by this block.

---
 rtl/ram_single_port_arbiter_if.sv | 25 ++
 rtl/ram_single_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_single_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_single_port_arbiter_if.sv
// ============================================================================
// Module      : ram_single_port_arbiter_if
// Description : One requester port of the shared-RAM arbiter; the command
//               handshake goes one way and the read return comes back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_single_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16
);
  logic                     valid;
  logic                     ready;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    di;
  logic                     rd_valid;
  logic [DATA_WIDTH-1:0]    rd_data;

  modport master (output valid, we, addr, di, input ready, rd_valid, rd_data);
  modport slave  (input valid, we, addr, di, output ready, rd_valid, rd_data);
endinterface

`default_nettype wire

// File: rtl/ram_single_port_arbiter.sv
// ============================================================================
// Module      : ram_single_port_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               RAM with registered RAM pins and a 3-cycle read return.
//               Define RAM_ARB_FIXED_PRIORITY_EN to make port 0 always win.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_single_port_arbiter #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  ram_single_port_arbiter_if.slave      p0_if,
  ram_single_port_arbiter_if.slave      p1_if,
  output logic                          ram_en_o,
  output logic                          ram_we_o,
  output logic [ADDRESS_WIDTH-1:0]      ram_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_di_o,
  input  wire logic [DATA_WIDTH-1:0]    ram_do_i
);

  logic                     grant0;
  logic                     grant1;
  logic                     accept;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_di;

  logic                     ram_en_q,   ram_en_d;
  logic                     ram_we_q,   ram_we_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_di_q,   ram_di_d;

  logic                     tag1_vld_q, tag1_vld_d;
  logic                     tag1_port_q, tag1_port_d;
  logic                     tag2_vld_q, tag2_vld_d;
  logic                     tag2_port_q, tag2_port_d;

  logic                     rd_valid0_q, rd_valid0_d;
  logic                     rd_valid1_q, rd_valid1_d;
  logic [DATA_WIDTH-1:0]    rd_data0_q,  rd_data0_d;
  logic [DATA_WIDTH-1:0]    rd_data1_q,  rd_data1_d;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant0 = rst_n & p0_if.valid;
    grant1 = rst_n & p1_if.valid & ~p0_if.valid;
  end
`else
  // last_grant_q = 1 means port 1 was served last, so port 0 wins a tie.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant0       = rst_n & p0_if.valid & (~p1_if.valid | last_grant_q);
    grant1       = rst_n & p1_if.valid & (~p0_if.valid | ~last_grant_q);
    last_grant_d = (grant0 | grant1) ? grant1 : last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    accept   = grant0 | grant1;
    sel_we   = grant1 ? p1_if.we   : p0_if.we;
    sel_addr = grant1 ? p1_if.addr : p0_if.addr;
    sel_di   = grant1 ? p1_if.di   : p0_if.di;

    ram_en_d   = accept;
    ram_we_d   = accept & sel_we;
    ram_addr_d = accept ? sel_addr : ram_addr_q;
    ram_di_d   = accept ? sel_di   : ram_di_q;

    tag1_vld_d  = accept & ~sel_we;
    tag1_port_d = grant1;
    tag2_vld_d  = tag1_vld_q;
    tag2_port_d = tag1_port_q;

    // ram_do_i is valid while tag2 is live; non-target port keeps its data.
    rd_valid0_d = tag2_vld_q & ~tag2_port_q;
    rd_valid1_d = tag2_vld_q &  tag2_port_q;
    rd_data0_d  = rd_valid0_d ? ram_do_i : rd_data0_q;
    rd_data1_d  = rd_valid1_d ? ram_do_i : rd_data1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_di_q    <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_port_q <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag2_port_q <= 1'b0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_di_q    <= ram_di_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_port_q <= tag1_port_d;
      tag2_vld_q  <= tag2_vld_d;
      tag2_port_q <= tag2_port_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
      rd_data0_q  <= rd_data0_d;
      rd_data1_q  <= rd_data1_d;
    end
  end

  assign p0_if.ready    = grant0;
  assign p1_if.ready    = grant1;
  assign p0_if.rd_valid = rd_valid0_q;
  assign p1_if.rd_valid = rd_valid1_q;
  assign p0_if.rd_data  = rd_data0_q;
  assign p1_if.rd_data  = rd_data1_q;

  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_di_o   = ram_di_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_single_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_single_port_arbiter
// Description : Directed bench with a behavioural RAM and a read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_single_port_arbiter;

  typedef struct packed { logic we; logic [9:0] addr; logic [15:0] di; } cmd_t;
  typedef struct { logic port; logic [15:0] data; int cyc; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_di;
  logic [15:0] ram_do = 16'h0;
  logic [15:0] ram_mem [1024];
  logic [15:0] ref_mem [1024];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rd_seen = 0;
  cmd_t cq0[$], cq1[$];
  exp_t sb[$];
  int   gseq[$], rcyc1[$];

  logic        model_lg;
  logic        prev_acc, prev_we;
  logic [9:0]  prev_addr;
  logic [15:0] prev_di, last0, last1;

  ram_single_port_arbiter_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(16)) p0_if ();
  ram_single_port_arbiter_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(16)) p1_if ();

  ram_single_port_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_if      (p0_if),
    .p1_if      (p1_if),
    .ram_en_o   (ram_en),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_di_o   (ram_di),
    .ram_do_i   (ram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, one-cycle read, NO_CHANGE on writes.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_di;
      else        ram_do <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checker: RAM command stage, arbitration, scoreboard push/pop.
  always @(negedge clk) begin
    logic er0, er1, a0, a1;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_acc = 1'b0;
      model_lg = 1'b1;
      last0 = 16'h0;
      last1 = 16'h0;
    end else begin
      if (prev_acc) begin
        chk("cmd_en",   ram_en,   1);
        chk("cmd_we",   ram_we,   prev_we);
        chk("cmd_addr", ram_addr, prev_addr);
        chk("cmd_di",   ram_di,   prev_di);
      end else begin
        chk("idle_en_we", {ram_en, ram_we}, 0);
      end
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      er0 = p0_if.valid;
      er1 = p1_if.valid && !p0_if.valid;
`else
      er0 = p0_if.valid && (!p1_if.valid || model_lg);
      er1 = p1_if.valid && (!p0_if.valid || !model_lg);
`endif
      chk("ready0", p0_if.ready, er0);
      chk("ready1", p1_if.ready, er1);
      a0 = er0;
      a1 = er1;
      prev_acc = a0 || a1;
      if (prev_acc) begin
        model_lg  = a1;
        prev_we   = a1 ? p1_if.we   : p0_if.we;
        prev_addr = a1 ? p1_if.addr : p0_if.addr;
        prev_di   = a1 ? p1_if.di   : p0_if.di;
        gseq.push_back(a1 ? 1 : 0);
        if (prev_we) ref_mem[prev_addr] = prev_di;
        else begin
          e.port = a1;
          e.data = ref_mem[prev_addr];
          e.cyc  = cyc;
          sb.push_back(e);
        end
      end
      if (p0_if.rd_valid || p1_if.rd_valid) begin
        rd_seen++;
        if (p1_if.rd_valid) rcyc1.push_back(cyc);
        chk("rd_onehot", p0_if.rd_valid & p1_if.rd_valid, 0);
        if (sb.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rd_port", p1_if.rd_valid, e.port);
          chk("rd_latency", cyc, e.cyc + 3);
          if (e.port) begin
            chk("rd_data1", p1_if.rd_data, e.data);
            chk("hold_data0", p0_if.rd_data, last0);
            last1 = e.data;
          end else begin
            chk("rd_data0", p0_if.rd_data, e.data);
            chk("hold_data1", p1_if.rd_data, last1);
            last0 = e.data;
          end
        end
      end
    end
  end

  task automatic load0();
    cmd_t c;
    if (cq0.size() > 0) begin
      c = cq0.pop_front();
      p0_if.valid = 1'b1; p0_if.we = c.we; p0_if.addr = c.addr; p0_if.di = c.di;
    end else p0_if.valid = 1'b0;
  endtask

  task automatic load1();
    cmd_t c;
    if (cq1.size() > 0) begin
      c = cq1.pop_front();
      p1_if.valid = 1'b1; p1_if.we = c.we; p1_if.addr = c.addr; p1_if.di = c.di;
    end else p1_if.valid = 1'b0;
  endtask

  // Requesters hold each command until accepted, then present the next one.
  task automatic run(input int budget);
    logic a0, a1;
    int   n = 0;
    load0();
    load1();
    while ((p0_if.valid || p1_if.valid) && n < budget) begin
      @(negedge clk);
      a0 = p0_if.valid && p0_if.ready;
      a1 = p1_if.valid && p1_if.ready;
      @(posedge clk); #1;
      if (a0) load0();
      if (a1) load1();
      n++;
    end
    chk("run_timeout", p0_if.valid || p1_if.valid, 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    ram_en,   0);
    chk({tag, "_we"},    ram_we,   0);
    chk({tag, "_addr"},  ram_addr, 0);
    chk({tag, "_di"},    ram_di,   0);
    chk({tag, "_rdy"},   {p0_if.ready, p1_if.ready}, 0);
    chk({tag, "_rdv"},   {p0_if.rd_valid, p1_if.rd_valid}, 0);
    chk({tag, "_rdd0"},  p0_if.rd_data, 0);
    chk({tag, "_rdd1"},  p1_if.rd_data, 0);
  endtask

  function automatic cmd_t mk(input logic we, input logic [9:0] a, input logic [15:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.di = d;
    return c;
  endfunction

  initial begin
    int s;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    rst_n = 1'b0;
    p0_if.valid = 1'b1; p0_if.we = 1'b0; p0_if.addr = 10'h0; p0_if.di = 16'h0;
    p1_if.valid = 1'b0; p1_if.we = 1'b0; p1_if.addr = 10'h0; p1_if.di = 16'h0;

    // Reset with a pending port 0 request, then first grant on release.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_ready0", p0_if.ready, 1);
    @(posedge clk); #1;
    p0_if.valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Port 0 write then read of the same address.
    cq0.push_back(mk(1'b1, 10'h005, 16'h1234));
    cq0.push_back(mk(1'b0, 10'h005, 16'h0000));
    run(20);
    chk("wr_rd_value", last0, 16'h1234);

    // Preload under contention, then a port 1 write so port 0 wins next.
    for (int i = 0; i < 6; i += 2) begin
      cq0.push_back(mk(1'b1, 10'h020 + 10'(i),     16'h1020 + 16'(i)));
      cq1.push_back(mk(1'b1, 10'h021 + 10'(i),     16'h1021 + 16'(i)));
    end
    run(30);
    cq1.push_back(mk(1'b1, 10'h030, 16'h5A5A));
    run(10);

    // Continuous contention for 6 reads.
    for (int i = 0; i < 6; i += 2) begin
      cq0.push_back(mk(1'b0, 10'h020 + 10'(i), 16'h0));
      cq1.push_back(mk(1'b0, 10'h021 + 10'(i), 16'h0));
    end
    gseq.delete();
    run(30);
    chk("contend_count", gseq.size(), 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      s = (i < 3) ? 0 : 1;
`else
      s = i % 2;
`endif
      chk("contend_grant", gseq[i], s);
    end

    // Port 1 back-to-back writes and reads at 0x010..0x013.
    for (int i = 0; i < 4; i++) cq1.push_back(mk(1'b1, 10'h010 + 10'(i), 16'hA000 + 16'(i * 17)));
    run(20);
    for (int i = 0; i < 4; i++) cq1.push_back(mk(1'b0, 10'h010 + 10'(i), 16'h0));
    rcyc1.delete();
    run(20);
    chk("b2b_count", rcyc1.size(), 4);
    for (int i = 1; i < 4 && i < rcyc1.size(); i++) chk("b2b_consecutive", rcyc1[i] - rcyc1[i-1], 1);
    chk("b2b_last", last1, 16'hA000 + 16'(3 * 17));

    // Same-address requests from both ports, and write-then-read on port 0.
    cq0.push_back(mk(1'b1, 10'h040, 16'hBEEF));
    cq1.push_back(mk(1'b0, 10'h040, 16'h0));
    cq0.push_back(mk(1'b1, 10'h041, 16'hCAFE));
    cq0.push_back(mk(1'b0, 10'h041, 16'h0));
    run(20);
    chk("raw_value", last0, 16'hCAFE);

    // Reset one cycle after a read handshake drops the read.
    p0_if.valid = 1'b1; p0_if.we = 1'b0; p0_if.addr = 10'h020;
    @(negedge clk);
    chk("mf_ready0", p0_if.ready, 1);
    @(posedge clk); #1;
    p0_if.valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("mfrst");
    s = rd_seen;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mf_no_return", rd_seen - s, 0);

    // Arbiter restarts favouring port 0.
    cq0.push_back(mk(1'b0, 10'h022, 16'h0));
    cq1.push_back(mk(1'b0, 10'h023, 16'h0));
    gseq.delete();
    run(20);
    chk("post_rst_first", (gseq.size() > 0) ? gseq[0] : 99, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
